// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the logic-instruction control sequencer:
// state encoding, opcode constants and the packed control word.
package cpu_ctrl_pkg;

  localparam int OPW = 5;

  typedef enum logic [2:0] {
    RST,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    HALT
  } state_e;

  localparam logic [OPW-1:0] OP_AND = 5'b01010;
  localparam logic [OPW-1:0] OP_OR  = 5'b01011;
  localparam logic [OPW-1:0] OP_NOT = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP = 5'b11010;
  localparam logic [OPW-1:0] OP_HLT = 5'b11011;

  // One bit per datapath control line plus the run indicator.
  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic r_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic r_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic alu_not;
    logic alu_or;
    logic alu_and;
    logic run;
  } ctrl_t;

  // Opcodes that have an execute phase (T3 onwards).
  function automatic logic is_exec_op(input logic [OPW-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_control_sequencer.sv
// Moore control unit stepping the datapath through fetch (T0-T2) and the
// execute steps of the AND/OR/NOT instructions, with a memory-read stall
// in T1 and a sticky halt request honoured at instruction boundaries.
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD = 32,
  parameter int OPW  = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [WORD-1:0] IR,
  input  logic            MemDone,
  input  logic            Stop,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Rout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Rin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            NOT,
  output logic            OR,
  output logic            AND,
  output logic            Run
);

  state_e         state;
  state_e         state_next;
  state_e         boundary;
  logic [OPW-1:0] opcode;
  logic           stop_pending;
  logic           t1_first;
  ctrl_t          ctrl;

  // Only the opcode field of IR is decoded; the operand fields belong to
  // the register-file decoder.
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR[WORD-OPW-1:0];

  // A halt request seen this cycle or earlier diverts the next T0 to HALT.
  assign boundary = (stop_pending || Stop) ? HALT : T0;

  // State register, stop-pending flag and first-T1-cycle marker.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RST;
      stop_pending <= 1'b0;
      t1_first     <= 1'b0;
    end else begin
      state        <= state_next;
      stop_pending <= stop_pending | Stop;
      t1_first     <= (state == T0);
    end
  end

  // Opcode capture while the fetched word is on IR.
  // NOTE: no reset here; the opcode is only decoded from T2 onwards, which
  // is always preceded by a T1 that loads it.
  always_ff @(posedge clock) begin
    if (state == T1) begin
      opcode <= IR[WORD-1 -: OPW];
    end
  end

  // Next-state logic.
  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational; a missing branch would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      RST:  state_next = boundary;
      T0:   state_next = T1;
      T1:   state_next = MemDone ? T2 : T1;
      T2: begin
        if (is_exec_op(opcode))    state_next = T3;
        else if (opcode == OP_NOP) state_next = boundary;
        else                       state_next = HALT;
      end
      T3:   state_next = T4;
      T4:   state_next = (opcode == OP_NOT) ? boundary : T5;
      T5:   state_next = boundary;
      HALT: state_next = HALT;
      default: state_next = RST;
    endcase
  end

  // Control word decode from state and latched opcode only.
  always_comb begin
    ctrl     = '0;
    ctrl.run = 1'b1;
    unique case (state)
      RST: ;
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      T1: begin
        ctrl.zlow_out = t1_first;
        ctrl.pc_in    = t1_first;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      T3: begin
        ctrl.grb   = 1'b1;
        ctrl.r_out = 1'b1;
        if (opcode == OP_NOT) begin
          ctrl.alu_not = 1'b1;
          ctrl.z_in    = 1'b1;
        end else begin
          ctrl.y_in = 1'b1;
        end
      end
      T4: begin
        if (opcode == OP_NOT) begin
          ctrl.zlow_out = 1'b1;
          ctrl.gra      = 1'b1;
          ctrl.r_in     = 1'b1;
        end else begin
          ctrl.grc     = 1'b1;
          ctrl.r_out   = 1'b1;
          ctrl.z_in    = 1'b1;
          ctrl.alu_and = (opcode == OP_AND);
          ctrl.alu_or  = (opcode == OP_OR);
        end
      end
      T5: begin
        ctrl.zlow_out = 1'b1;
        ctrl.gra      = 1'b1;
        ctrl.r_in     = 1'b1;
      end
      HALT: ctrl.run = 1'b0;
      default: ctrl = '0;
    endcase
  end

  assign PCout   = ctrl.pc_out;
  assign Zlowout = ctrl.zlow_out;
  assign MDRout  = ctrl.mdr_out;
  assign Rout    = ctrl.r_out;
  assign MARin   = ctrl.mar_in;
  assign PCin    = ctrl.pc_in;
  assign MDRin   = ctrl.mdr_in;
  assign IRin    = ctrl.ir_in;
  assign Yin     = ctrl.y_in;
  assign Zin     = ctrl.z_in;
  assign Rin     = ctrl.r_in;
  assign IncPC   = ctrl.inc_pc;
  assign Read    = ctrl.read;
  assign Gra     = ctrl.gra;
  assign Grb     = ctrl.grb;
  assign Grc     = ctrl.grc;
  assign NOT     = ctrl.alu_not;
  assign OR      = ctrl.alu_or;
  assign AND     = ctrl.alu_and;
  assign Run     = ctrl.run;

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Moore control unit that generates the per-step datapath control signals, including the NOT/OR/AND select lines consumed by the ALU.
- Steps the CPU datapath through fetch (T0-T2) and execute (T3-T5) for the logic instructions, stalling on the memory read handshake.
- Sits beside the datapath. Its inputs are IR and the memory-done flag; it drives every register-enable, bus-out and ALU-select line.

Parameters:
- WORD, 32, instruction register width
- OPW, 5, opcode width; opcode occupies IR[WORD-1:WORD-OPW]

Ports:
- clock  input  1  single system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- IR  input  WORD  current instruction register contents
- MemDone  input  1  memory read data valid, qualifies the T1 stall
- Stop  input  1  request halt at next instruction boundary
- PCout, Zlowout, MDRout, Rout  output  1 each  bus drive enables
- MARin, PCin, MDRin, IRin, Yin, Zin, Rin  output  1 each  register load enables
- IncPC  output  1  ALU passes PC+1 into Z
- Read  output  1  memory read strobe
- Gra, Grb, Grc  output  1 each  register-field select for the register-file decoder
- NOT, OR, AND  output  1 each  ALU operation selects, at most one high
- Run  output  1  high while executing, low in HALT

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising clock edge. Reset overrides all other inputs.
- State register values: RST, T0, T1, T2, T3, T4, T5, HALT. Opcode constants shared via package.
- Outputs are pure decode of the state register plus the latched opcode. No output decodes inputs combinationally.
- Reset:
  - Next state is RST.
  - In RST every control output is 0 and Run=1.
  - RST -> T0 unconditionally on the next cycle.
  - Reset asserted in any state, including a T1 stall or HALT, aborts the instruction and returns to RST.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. PCin and Zlowout are high in the first T1 cycle only. Read and MDRin stay high until MemDone=1, then T1 -> T2.
  - T2: MDRout, IRin. The opcode is latched from the IR input at the end of T1.
- Decode at T2 -> next state:
  - AND 5'b01010, OR 5'b01011, NOT 5'b10010: go to T3.
  - NOP 5'b11010: go to T0.
  - HLT 5'b11011 and any other opcode (illegal): go to HALT.
- AND/OR execute:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, the AND or OR select, Zin.
  - T5: Zlowout, Gra, Rin. T5 -> T0.
- NOT execute:
  - T3: Grb, Rout, NOT, Zin.
  - T4: Zlowout, Gra, Rin. T4 -> T0. T5 is skipped.
- ALU selects: exactly one of NOT/OR/AND is high in the Zin execute step, and all three are 0 in every other state.
- Latency with MemDone high in the first T1 cycle: AND/OR 6 cycles, NOT 5, NOP 3. Each extra cycle with MemDone low adds one cycle.
- Stop:
  - Sampled every cycle and held in a sticky pending flag.
  - The flag is checked on the transition that would enter T0: pending means go to HALT instead.
  - An instruction in progress always completes. Stop during RST takes effect when RST would go to T0.
- HALT: all control outputs 0, Run=0. Left only by reset.
- MemDone outside T1 is ignored.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding as a typedef enum;
  - opcode localparams (OP_AND, OP_OR, OP_NOT, OP_NOP, OP_HLT);
  - OPW.
- No sub-module is needed: a single FSM with a next-state block, an output decode block, and the opcode and stop-pending registers.

Test Plan:
- Reset, then AND (IR=32'h5000_0000), MemDone high from the first T1 cycle -> sequence RST,T0,T1,T2,T3,T4,T5,T0. AND=1 only in T4 with Grc, Rout, Zin. Run=1 throughout.
- NOT (IR=32'h9000_0000), MemDone low for 3 T1 cycles -> Read and MDRin high for 4 cycles, PCin high only in the first. NOT=1 in T3 with Zin. T4 -> T0. Total 8 cycles.
- OR then NOP back-to-back -> OR=1 only in the OR T4. NOP returns T2 -> T0 with no Yin, Zin or Rin asserted.
- Illegal opcode 5'b00000 and HLT 5'b11011 -> HALT after T2. All outputs 0, Run=0, state held for 20 cycles.
- Stop pulsed 1 cycle during the AND T3 -> T5 completes with Rin=1, then HALT instead of T0.
- Reset asserted mid-T4 of OR -> next cycle RST, OR=0, Zin=0, then T0. HALT -> reset -> RST with Run=1.
